// File: rtl/rename_pkg.sv
// Shared types and sizes for the register renamer and its commit-side consumers.
package rename_pkg;
    localparam int NUM_AREG = 32;
    localparam int NUM_PREG = 64;
    localparam int AREG_W   = 5;
    localparam int PREG_W   = 6;
    localparam int FL_DEPTH = NUM_PREG - NUM_AREG;
    localparam int FL_IDX_W = 5;

    typedef logic [AREG_W-1:0]   areg_t;
    typedef logic [PREG_W-1:0]   preg_t;
    // Free-list pointer: 5-bit index plus a wrap bit so 32 entries and 0 entries differ.
    typedef logic [FL_IDX_W:0]   fl_ptr_t;

    typedef struct packed {
        logic  valid;
        areg_t rd;
        preg_t pr;
        preg_t old_pr;
    } commit_t;

    function automatic fl_ptr_t ptr_inc(input fl_ptr_t p);
        return p + fl_ptr_t'(1);
    endfunction
endpackage

// File: rtl/rename_unit_if.sv
// Decode/commit/flush bundle between the front end, the ROB and the renamer.
interface rename_unit_if;
    import rename_pkg::*;

    logic    rn_valid;
    logic    rn_rd_we;
    areg_t   rn_rd;
    areg_t   rn_rs1;
    areg_t   rn_rs2;
    logic    rn_ready;
    preg_t   rn_pr;
    preg_t   rn_old_pr;
    preg_t   rn_rs1_pr;
    preg_t   rn_rs2_pr;
    logic    cm_valid;
    areg_t   cm_rd;
    preg_t   cm_pr;
    preg_t   cm_old_pr;
    logic    flush;
    fl_ptr_t free_count;

    modport master (
        output rn_valid, rn_rd_we, rn_rd, rn_rs1, rn_rs2,
        output cm_valid, cm_rd, cm_pr, cm_old_pr, flush,
        input  rn_ready, rn_pr, rn_old_pr, rn_rs1_pr, rn_rs2_pr, free_count
    );

    modport slave (
        input  rn_valid, rn_rd_we, rn_rd, rn_rs1, rn_rs2,
        input  cm_valid, cm_rd, cm_pr, cm_old_pr, flush,
        output rn_ready, rn_pr, rn_old_pr, rn_rs1_pr, rn_rs2_pr, free_count
    );
endinterface

// File: rtl/rename_freelist.sv
// Circular free list of physical registers: speculative head, committed head and tail.
module rename_freelist
    import rename_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    pop,
    input  logic    push,
    input  preg_t   push_pr,
    input  logic    restore,
    output preg_t   head_pr,
    output fl_ptr_t count
);
    fl_ptr_t head_reg;
    fl_ptr_t tail_reg;
    fl_ptr_t chead_reg;
    fl_ptr_t chead_next;
    preg_t   entries [FL_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < FL_DEPTH; gi++) begin : g_entry
            preg_t entry_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= preg_t'(FL_DEPTH + gi);
                end else if (push && tail_reg[FL_IDX_W-1:0] == FL_IDX_W'(gi)) begin
                    entry_reg <= push_pr;
                end
            end
            assign entries[gi] = entry_reg;
        end
    endgenerate

    // A commit in the flush cycle retires one more rename, so restore lands past it.
    assign chead_next = push ? ptr_inc(chead_reg) : chead_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= fl_ptr_t'(FL_DEPTH);
            chead_reg <= '0;
        end else begin
            chead_reg <= chead_next;
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (restore) begin
                head_reg <= chead_next;
            end else if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
        end
    end

    assign count   = tail_reg - head_reg;
    assign head_pr = entries[head_reg[FL_IDX_W-1:0]];

    push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(push && count == fl_ptr_t'(FL_DEPTH)));
endmodule

// File: rtl/rename_unit.sv
// Speculative/architectural RAT pair with free-list allocation, commit retirement and one-cycle flush.
module rename_unit
    import rename_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    rename_unit_if.slave bus
);
    commit_t cm;
    logic    alloc;
    logic    ready;
    logic    do_rename;
    logic    do_commit;
    preg_t   head_pr;
    fl_ptr_t count;
    preg_t   spec_rat [NUM_AREG];

    assign cm        = '{valid: bus.cm_valid, rd: bus.cm_rd, pr: bus.cm_pr, old_pr: bus.cm_old_pr};
    assign do_commit = cm.valid && (cm.rd != '0);
    assign alloc     = bus.rn_valid && bus.rn_rd_we && (bus.rn_rd != '0);
    assign ready     = !bus.flush && (!alloc || count != '0);
    assign do_rename = bus.rn_valid && ready && alloc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_AREG; gi++) begin : g_rat
            preg_t spec_reg;
            preg_t arch_reg;
            preg_t arch_next;
            logic  cm_hit;
            logic  rn_hit;

            assign cm_hit    = do_commit && (cm.rd == AREG_W'(gi));
            assign rn_hit    = do_rename && (bus.rn_rd == AREG_W'(gi));
            assign arch_next = cm_hit ? cm.pr : arch_reg;

            // Flush copies the post-commit architectural view, including this cycle's commit.
            always_ff @(posedge clk) begin
                if (rst) begin
                    spec_reg <= PREG_W'(gi);
                    arch_reg <= PREG_W'(gi);
                end else begin
                    arch_reg <= arch_next;
                    if (bus.flush) begin
                        spec_reg <= arch_next;
                    end else if (rn_hit) begin
                        spec_reg <= head_pr;
                    end
                end
            end
            assign spec_rat[gi] = spec_reg;
        end
    endgenerate

    rename_freelist u_freelist (
        .clk     (clk),
        .rst     (rst),
        .pop     (do_rename),
        .push    (do_commit),
        .push_pr (cm.old_pr),
        .restore (bus.flush),
        .head_pr (head_pr),
        .count   (count)
    );

    assign bus.rn_ready   = ready;
    assign bus.rn_pr      = alloc ? head_pr : '0;
    assign bus.rn_old_pr  = spec_rat[bus.rn_rd];
    assign bus.rn_rs1_pr  = spec_rat[bus.rn_rs1];
    assign bus.rn_rs2_pr  = spec_rat[bus.rn_rs2];
    assign bus.free_count = count;
endmodule
